tqvp_bus_arbiter: RTL and testbench
===================================

TQVP_BUS_ARBITER -- requirements
Module: tqvp_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of READ cycles without p_data_ready before the read is abandoned; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 reqN_address  input  6  register address from requester N, N in {0,1}.
REQ-005 reqN_data_in  input  32  write data from requester N.
REQ-006 reqN_write_n  input  2  requester N write size: 00 byte, 01 half, 10 word, 11 none.
REQ-007 reqN_read_n  input  2  requester N read size, same encoding as write.
REQ-008 reqN_data_out  output  32  last read data returned to requester N.
REQ-009 reqN_done  output  1  one-cycle completion pulse to requester N.
REQ-010 p_address  output  6  peripheral register address.
REQ-011 p_data_in  output  32  peripheral write data.
REQ-012 p_write_n  output  2  peripheral write strobe/size, 11 idle.
REQ-013 p_read_n  output  2  peripheral read strobe/size, 11 idle.
REQ-014 p_data_out  input  32  peripheral read data.
REQ-015 p_data_ready  input  1  peripheral read data valid.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 timeout_err  output  1  pulses with reqN_done when a read timed out.

Function
REQ-018 Requester N is pending when reqN_write_n != 11 or reqN_read_n != 11; the requester SHALL hold all its inputs stable until it samples its reqN_done high, then drop the request on that same edge.
REQ-019 FSM states SHALL be IDLE, WRITE, READ, DONE; any other encoding SHALL return to IDLE.
REQ-020 IDLE: with no pending request, stay; otherwise grant one requester, latch its address, data, size and direction, go to WRITE (write pending) or READ.
REQ-021 If both requesters are pending in IDLE, grant SHALL go to the requester not granted last (round-robin pointer last_grant); a single pending requester SHALL be granted regardless of the pointer.
REQ-022 If a requester asserts both write_n and read_n != 11, it SHALL be treated as a write.
REQ-023 WRITE: p_write_n = latched size, p_address and p_data_in = latched values for exactly one cycle, then DONE.
REQ-024 READ: p_read_n = latched size, p_address = latched address, held every cycle until p_data_ready=1; on that cycle capture p_data_out into the granted reqN_data_out and go DONE.
REQ-025 READ SHALL use an 8-bit cycle counter cleared on entry; if TIMEOUT READ cycles elapse without p_data_ready, load 32'h0 into reqN_data_out, set timeout_err for the DONE cycle, and go DONE.
REQ-026 p_write_n and p_read_n SHALL be 11 in IDLE and DONE; never both active in one cycle.
REQ-027 DONE: reqN_done=1 for the granted requester only, for exactly one cycle; last_grant updated to that requester; next state IDLE.
REQ-028 Latency: write or zero-wait read completes with reqN_done high in the second cycle after the request is first seen in IDLE; each extra cycle before p_data_ready adds one cycle.
REQ-029 reqN_data_out SHALL hold its value until the next read completion for requester N; writes and the other requester leave it unchanged.
REQ-030 Requests arriving while busy SHALL be held pending and never dropped; the ungranted requester waits without a done pulse.

Reset
REQ-031 On rst_n=0, immediately and independent of clk: state IDLE, p_write_n=p_read_n=11, p_address=0, p_data_in=0, reqN_data_out=0, reqN_done=0, busy=0, timeout_err=0, counter=0, last_grant=1 (so requester 0 wins the first tie).
REQ-032 Reset during WRITE or READ SHALL abort the transfer with no done pulse issued after reset releases.

Verification
REQ-033 Assert rst_n=0 mid-READ (p_read_n=10) -> p_read_n=11, busy=0 before next clk edge; no reqN_done after release.
REQ-034 req0 word write addr 6'h04 data 32'h12345678 -> p_write_n=10, p_address=04, p_data_in=12345678 for one cycle; req0_done in cycle 2.
REQ-035 req1 byte read addr 6'h10, p_data_ready after 3 READ cycles with 32'h000000A5 -> p_read_n=00 for 3 cycles; req1_data_out=000000A5, req1_done in cycle 4.
REQ-036 Both requesters write continuously from reset -> grants alternate 0,1,0,1; each done pulse single-cycle, on the matching requester.
REQ-037 req0 read with p_data_ready held 0, TIMEOUT=255 -> p_read_n released after 255 READ cycles; req0_done and timeout_err together, req0_data_out=0.

Source files
------------

// File: rtl/tqvp_bus_arbiter_if.sv
// Bus bundle between two register requesters, the arbiter and one peripheral.
// The master modport is the arbiter's view; slave is the requester/peripheral side.
interface tqvp_bus_arbiter_if;
    logic [5:0]  req0_address;
    logic [31:0] req0_data_in;
    logic [1:0]  req0_write_n;
    logic [1:0]  req0_read_n;
    logic [31:0] req0_data_out;
    logic        req0_done;

    logic [5:0]  req1_address;
    logic [31:0] req1_data_in;
    logic [1:0]  req1_write_n;
    logic [1:0]  req1_read_n;
    logic [31:0] req1_data_out;
    logic        req1_done;

    logic [5:0]  p_address;
    logic [31:0] p_data_in;
    logic [1:0]  p_write_n;
    logic [1:0]  p_read_n;
    logic [31:0] p_data_out;
    logic        p_data_ready;

    modport master (
        input  req0_address, req0_data_in, req0_write_n, req0_read_n,
        output req0_data_out, req0_done,
        input  req1_address, req1_data_in, req1_write_n, req1_read_n,
        output req1_data_out, req1_done,
        output p_address, p_data_in, p_write_n, p_read_n,
        input  p_data_out, p_data_ready
    );

    modport slave (
        output req0_address, req0_data_in, req0_write_n, req0_read_n,
        input  req0_data_out, req0_done,
        output req1_address, req1_data_in, req1_write_n, req1_read_n,
        input  req1_data_out, req1_done,
        input  p_address, p_data_in, p_write_n, p_read_n,
        output p_data_out, p_data_ready
    );
endinterface

// File: rtl/tqvp_bus_arbiter.sv
// Two-requester round-robin arbiter onto a single peripheral register port,
// with single-cycle writes, ready-terminated reads and a read timeout.
module tqvp_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    tqvp_bus_arbiter_if.master  bus,
    output logic                busy,
    output logic                timeout_err
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [1:0] SZ_NONE = 2'b11;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        grant_q;
    logic        last_grant_q;
    logic [7:0]  cnt_q;
    logic [5:0]  p_address_q;
    logic [31:0] p_data_in_q;
    logic [1:0]  p_write_n_q;
    logic [1:0]  p_read_n_q;
    logic [31:0] dout0_q;
    logic [31:0] dout1_q;
    logic [1:0]  done_q;
    logic        busy_q;
    logic        to_q;

    logic        pend0, pend1;
    logic        gnt_d;
    logic [5:0]  sel_addr;
    logic [31:0] sel_data;
    logic [1:0]  sel_wn;
    logic [1:0]  sel_rn;

    assign pend0 = (bus.req0_write_n != SZ_NONE) || (bus.req0_read_n != SZ_NONE);
    assign pend1 = (bus.req1_write_n != SZ_NONE) || (bus.req1_read_n != SZ_NONE);

    // A tie goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        gnt_d    = 1'b0;
        sel_addr = bus.req0_address;
        sel_data = bus.req0_data_in;
        sel_wn   = bus.req0_write_n;
        sel_rn   = bus.req0_read_n;
        if (pend0 && pend1) begin
            gnt_d = ~last_grant_q;
        end else begin
            gnt_d = ~pend0;
        end
        if (gnt_d) begin
            sel_addr = bus.req1_address;
            sel_data = bus.req1_data_in;
            sel_wn   = bus.req1_write_n;
            sel_rn   = bus.req1_read_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
            p_address_q  <= 6'd0;
            p_data_in_q  <= 32'd0;
            p_write_n_q  <= SZ_NONE;
            p_read_n_q   <= SZ_NONE;
            dout0_q      <= 32'd0;
            dout1_q      <= 32'd0;
            done_q       <= 2'b00;
            busy_q       <= 1'b0;
            to_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend0 || pend1) begin
                        grant_q     <= gnt_d;
                        p_address_q <= sel_addr;
                        p_data_in_q <= sel_data;
                        busy_q      <= 1'b1;
                        cnt_q       <= 8'd0;
                        // A request carrying both a write and a read size is a write.
                        if (sel_wn != SZ_NONE) begin
                            p_write_n_q <= sel_wn;
                            state_q     <= WRITE;
                        end else begin
                            p_read_n_q <= sel_rn;
                            state_q    <= READ;
                        end
                    end
                end

                WRITE: begin
                    p_write_n_q     <= SZ_NONE;
                    done_q[grant_q] <= 1'b1;
                    state_q         <= DONE;
                end

                READ: begin
                    if (bus.p_data_ready) begin
                        if (grant_q) dout1_q <= bus.p_data_out;
                        else         dout0_q <= bus.p_data_out;
                        p_read_n_q      <= SZ_NONE;
                        done_q[grant_q] <= 1'b1;
                        state_q         <= DONE;
                    end else if (cnt_q == TO_LAST) begin
                        if (grant_q) dout1_q <= 32'd0;
                        else         dout0_q <= 32'd0;
                        p_read_n_q      <= SZ_NONE;
                        done_q[grant_q] <= 1'b1;
                        to_q            <= 1'b1;
                        state_q         <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                DONE: begin
                    done_q       <= 2'b00;
                    to_q         <= 1'b0;
                    busy_q       <= 1'b0;
                    last_grant_q <= grant_q;
                    state_q      <= IDLE;
                end

                default: begin
                    p_write_n_q <= SZ_NONE;
                    p_read_n_q  <= SZ_NONE;
                    done_q      <= 2'b00;
                    to_q        <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.p_address     = p_address_q;
    assign bus.p_data_in     = p_data_in_q;
    assign bus.p_write_n     = p_write_n_q;
    assign bus.p_read_n      = p_read_n_q;
    assign bus.req0_data_out = dout0_q;
    assign bus.req1_data_out = dout1_q;
    assign bus.req0_done     = done_q[0];
    assign bus.req1_done     = done_q[1];
    assign busy              = busy_q;
    assign timeout_err       = to_q;

endmodule

// File: tb/tb_tqvp_bus_arbiter.sv
// Scoreboard bench for tqvp_bus_arbiter: requesters push expected completions,
// a monitor pops them on every done pulse; a small peripheral model answers reads.
module tb_tqvp_bus_arbiter;

    localparam int TIMEOUT = 255;

    typedef struct {
        logic [31:0] data;
        logic        to;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic timeout_err;

    tqvp_bus_arbiter_if bus();

    tqvp_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   done_order[$];
    logic [31:0] model_dout [2];

    // peripheral model controls
    int          rd_wait = 1;
    logic [31:0] rd_data = 32'd0;
    int          rcnt    = 0;

    // peripheral activity statistics
    int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    logic [1:0]  last_pw = 2'b11, last_pr = 2'b11;
    logic [5:0]  last_pa = 6'd0;
    logic [31:0] last_pd = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int id);
        exp_t e;
        logic [31:0] dout;
        dout = (id == 1) ? bus.req1_data_out : bus.req0_data_out;
        if ((id == 1 && q1.size() == 0) || (id == 0 && q0.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL req%0d_unexpected_done actual=1 required=0 cycle=%0d", id, cyc);
        end else begin
            e = (id == 1) ? q1.pop_front() : q0.pop_front();
            chk($sformatf("req%0d_data_out", id), dout, e.data);
            chk($sformatf("req%0d_timeout_err", id), 32'(timeout_err), 32'(e.to));
            if (e.cyc >= 0) chk($sformatf("req%0d_done_cycle", id), 32'(cyc), 32'(e.cyc));
            done_order.push_back(id);
        end
    endtask

    // monitor: scoreboard on done pulses plus peripheral activity statistics
    always @(negedge clk) begin
        if (bus.req0_done && bus.req1_done) begin
            checks++;
            errors++;
            $display("FAIL done_exclusive actual=11 required=one_hot cycle=%0d", cyc);
        end
        if (bus.req0_done) sb_pop(0);
        if (bus.req1_done) sb_pop(1);
        if (bus.p_write_n != 2'b11 && bus.p_read_n != 2'b11) both_cnt++;
        if (bus.p_write_n != 2'b11) begin
            wr_cnt++;
            last_pw = bus.p_write_n;
            last_pa = bus.p_address;
            last_pd = bus.p_data_in;
        end
        if (bus.p_read_n != 2'b11) begin
            rd_cnt++;
            last_pr = bus.p_read_n;
            last_pa = bus.p_address;
        end
    end

    // peripheral: raise ready in the rd_wait-th READ cycle (0 = never)
    always @(negedge clk) begin
        bus.p_data_out = rd_data;
        if (bus.p_read_n != 2'b11) begin
            rcnt++;
            bus.p_data_ready = (rd_wait != 0) && (rcnt == rd_wait);
        end else begin
            rcnt = 0;
            bus.p_data_ready = 1'b0;
        end
    end

    // Issue one request at posedge+1, wait for its done, drop it on the sampling edge.
    task automatic do_req(input int id, input logic [1:0] wn, input logic [1:0] rn,
                          input logic [5:0] a, input logic [31:0] d,
                          input logic [31:0] exp_data, input logic exp_to, input int extra);
        exp_t e;
        bit   got = 1'b0;
        if (id == 1) begin
            bus.req1_address = a; bus.req1_data_in = d;
            bus.req1_write_n = wn; bus.req1_read_n = rn;
        end else begin
            bus.req0_address = a; bus.req0_data_in = d;
            bus.req0_write_n = wn; bus.req0_read_n = rn;
        end
        e.data = exp_data;
        e.to   = exp_to;
        e.cyc  = (extra < 0) ? -1 : cyc + 2 + extra;
        if (id == 1) q1.push_back(e); else q0.push_back(e);
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = (id == 1) ? bus.req1_done : bus.req0_done;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL req%0d_done_wait actual=none required=pulse", id);
        end
        @(posedge clk); #1;
        if (id == 1) begin
            bus.req1_write_n = 2'b11; bus.req1_read_n = 2'b11;
        end else begin
            bus.req0_write_n = 2'b11; bus.req0_read_n = 2'b11;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, r0;
        rst_n = 1'b0;
        bus.req0_address = '0; bus.req0_data_in = '0; bus.req0_write_n = 2'b11; bus.req0_read_n = 2'b11;
        bus.req1_address = '0; bus.req1_data_in = '0; bus.req1_write_n = 2'b11; bus.req1_read_n = 2'b11;
        bus.p_data_out = '0; bus.p_data_ready = 1'b0;
        model_dout[0] = 32'd0;
        model_dout[1] = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst_p_write_n", 32'(bus.p_write_n), 32'h3);
        chk("rst_p_read_n", 32'(bus.p_read_n), 32'h3);
        chk("rst_p_address", 32'(bus.p_address), 32'h0);
        chk("rst_p_data_in", bus.p_data_in, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk("rst_req0_data_out", bus.req0_data_out, 32'h0);
        chk("rst_req1_data_out", bus.req1_data_out, 32'h0);
        chk("rst_done", 32'({bus.req1_done, bus.req0_done}), 32'h0);

        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // both requesters write back-to-back from reset: grants 0,1,0,1,0,1
        done_order.delete();
        fork
            begin
                for (int i = 0; i < 3; i++)
                    do_req(0, 2'b10, 2'b11, 6'(32 + i), 32'(32'hA0 + i), model_dout[0], 1'b0, -1);
            end
            begin
                for (int j = 0; j < 3; j++)
                    do_req(1, 2'b10, 2'b11, 6'(48 + j), 32'(32'hB0 + j), model_dout[1], 1'b0, -1);
            end
        join
        chk("rr_count", 32'(done_order.size()), 32'd6);
        for (int k = 0; k < done_order.size(); k++)
            chk($sformatf("rr_grant_%0d", k), 32'(done_order[k]), 32'(k % 2));

        // req0 word write
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(0, 2'b10, 2'b11, 6'h04, 32'h12345678, model_dout[0], 1'b0, 0);
        chk("wr_strobe_cycles", 32'(wr_cnt - w0), 32'd1);
        chk("wr_no_read", 32'(rd_cnt - r0), 32'd0);
        chk("wr_p_write_n", 32'(last_pw), 32'h2);
        chk("wr_p_address", 32'(last_pa), 32'h04);
        chk("wr_p_data_in", last_pd, 32'h12345678);

        // req1 byte read, ready in third READ cycle
        rd_wait = 3; rd_data = 32'h000000A5;
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(1, 2'b11, 2'b00, 6'h10, 32'h0, 32'h000000A5, 1'b0, 2);
        model_dout[1] = 32'h000000A5;
        chk("rd_strobe_cycles", 32'(rd_cnt - r0), 32'd3);
        chk("rd_p_read_n", 32'(last_pr), 32'h0);
        chk("rd_p_address", 32'(last_pa), 32'h10);

        // req0 zero-wait word read; req1 data must stay put
        rd_wait = 1; rd_data = 32'hDEADBEEF;
        do_req(0, 2'b11, 2'b10, 6'h08, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        model_dout[0] = 32'hDEADBEEF;
        chk("req1_data_hold", bus.req1_data_out, 32'h000000A5);

        // write and read both requested: treated as a write
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(1, 2'b01, 2'b10, 6'h3F, 32'hCAFE0001, model_dout[1], 1'b0, 0);
        chk("rw_strobe_cycles", 32'(wr_cnt - w0), 32'd1);
        chk("rw_no_read", 32'(rd_cnt - r0), 32'd0);
        chk("rw_p_write_n", 32'(last_pw), 32'h1);
        chk("rw_p_address", 32'(last_pa), 32'h3F);
        chk("rw_p_data_in", last_pd, 32'hCAFE0001);

        // read timeout
        rd_wait = 0;
        r0 = rd_cnt;
        do_req(0, 2'b11, 2'b10, 6'h11, 32'h0, 32'h0, 1'b1, TIMEOUT - 1);
        model_dout[0] = 32'h0;
        chk("to_strobe_cycles", 32'(rd_cnt - r0), 32'(TIMEOUT));
        chk("to_req1_hold", bus.req1_data_out, 32'h000000A5);

        // asynchronous reset in the middle of a read
        bus.req0_address = 6'h02; bus.req0_read_n = 2'b10; bus.req0_write_n = 2'b11;
        repeat (5) @(negedge clk);
        chk("mid_p_read_n", 32'(bus.p_read_n), 32'h2);
        chk("mid_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_p_read_n", 32'(bus.p_read_n), 32'h3);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_p_address", 32'(bus.p_address), 32'h0);
        bus.req0_read_n = 2'b11;
        @(posedge clk); #1 rst_n = 1'b1;
        model_dout[0] = 32'h0;
        model_dout[1] = 32'h0;
        repeat (10) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_req1_data_out", bus.req1_data_out, 32'h0);

        // single pending requester wins even against the pointer
        @(posedge clk); #1;
        do_req(1, 2'b00, 2'b11, 6'h05, 32'h000000EE, model_dout[1], 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("sb_q0_empty", 32'(q0.size()), 32'd0);
        chk("sb_q1_empty", 32'(q1.size()), 32'd0);
        chk("never_both_strobes", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
